// File: rtl/fifo_frame_packer_pkg.sv
// Shared ADC readout types for the frame packer.
// Holds the header word layout, the framing FSM state encoding and the frame counter width.
package fifo_frame_packer_pkg;

    localparam int unsigned FRAME_CNT_W = 24;

    // Header word: marker byte on top, frame counter below.
    typedef struct packed {
        logic [7:0]             mark;
        logic [FRAME_CNT_W-1:0] cnt;
    } header_t;

    typedef enum logic [1:0] {
        StPass = 2'd0,
        StHdr  = 2'd1,
        StData = 2'd2
    } frame_state_e;

    function automatic logic [31:0] make_header(input logic [7:0]             mark,
                                                input logic [FRAME_CNT_W-1:0] cnt);
        header_t hdr;
        hdr.mark = mark;
        hdr.cnt  = cnt;
        return hdr;
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Generic 2-entry first-word-fall-through buffer with registered empty flag and head data.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and data (ignored when full, judged before this cycle's pop)
//   pop             read request (ignored when empty)
//   empty           registered empty flag
//   head_data       registered oldest entry
//   count           number of stored entries, 0..2
module fifo_skid2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok = push && (count_q != 2'd2);
        pop_ok  = pop && !empty_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        case (count_q)
            2'd0: begin
                if (push_ok) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                case ({push_ok, pop_ok})
                    2'b11: head_d = push_data;
                    2'b10: begin
                        tail_d  = push_data;
                        count_d = 2'd2;
                    end
                    2'b01: count_d = 2'd0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop_ok) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase

        empty_d = (count_d == 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    assign empty     = empty_q;
    assign head_data = head_q;
    assign count     = count_q;

endmodule

// File: rtl/fifo_frame_packer.sv
// Frame packer between the ADC round-robin arbiter and the SRAM output FIFO.
// While ENABLE is high, a header {HEADER_MARK, FRAME_CNT} precedes every WORDS_PER_FRAME
// data words; with ENABLE low, words pass through unchanged.
// Ports:
//   BUS_CLK, BUS_RST   clock, asynchronous active-high reset
//   ENABLE             level, header insertion on (applied at frame boundaries)
//   FRAME_RST          pulse, clears FRAME_CNT
//   FIFO_EMPTY_IN      upstream has no word
//   FIFO_DATA_IN       upstream word
//   FIFO_READ_OUT      upstream word accepted this cycle
//   FIFO_READ_IN       downstream pop
//   FIFO_EMPTY_OUT     output buffer empty (registered)
//   FIFO_DATA_OUT      output buffer head (registered)
//   FRAME_CNT          frames started since reset / FRAME_RST
module fifo_frame_packer
    import fifo_frame_packer_pkg::*;
#(
    parameter int unsigned WORDS_PER_FRAME = 1024,
    parameter logic [7:0]  HEADER_MARK     = 8'hF5
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST,
    input  logic                   ENABLE,
    input  logic                   FRAME_RST,
    input  logic                   FIFO_EMPTY_IN,
    input  logic [31:0]            FIFO_DATA_IN,
    output logic                   FIFO_READ_OUT,
    input  logic                   FIFO_READ_IN,
    output logic                   FIFO_EMPTY_OUT,
    output logic [31:0]            FIFO_DATA_OUT,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

    localparam int unsigned WCNT_W = $clog2(WORDS_PER_FRAME + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_FRAME - 1);

    frame_state_e           state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   frame_inc;

    logic                   buf_push;
    logic [31:0]            buf_data;
    logic                   buf_empty;
    logic [1:0]             buf_count;
    logic                   space;
    logic                   read_out;
    logic                   up_xfer;

    assign space   = (buf_count != 2'd2);
    assign up_xfer = read_out && !FIFO_EMPTY_IN;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        read_out  = 1'b0;
        buf_push  = 1'b0;
        buf_data  = FIFO_DATA_IN;
        frame_inc = 1'b0;

        case (state_q)
            StHdr: begin
                // Header only goes out once a data word is actually waiting.
                if (!FIFO_EMPTY_IN && space) begin
                    buf_push  = 1'b1;
                    buf_data  = make_header(HEADER_MARK, frame_cnt_q);
                    frame_inc = 1'b1;
                    wcnt_d    = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                read_out = space;
                if (up_xfer) begin
                    buf_push = 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        wcnt_d  = '0;
                        state_d = ENABLE ? StHdr : StPass;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            default: begin
                // Enabling takes a cycle with no upstream transfer so the first framed word
                // cannot slip out ahead of its header.
                read_out = space && !ENABLE;
                buf_push = up_xfer;
                if (ENABLE) begin
                    state_d = StHdr;
                end
            end
        endcase
    end

    // FRAME_RST wins over the increment; a coinciding header still carries the old count.
    assign frame_cnt_d = FRAME_RST ? '0 :
                         (frame_inc ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q);

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q     <= StPass;
            wcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fifo_skid2 #(
        .WIDTH (32)
    ) u_buf (
        .clk       (BUS_CLK),
        .rst       (BUS_RST),
        .push      (buf_push),
        .push_data (buf_data),
        .pop       (FIFO_READ_IN),
        .empty     (buf_empty),
        .head_data (FIFO_DATA_OUT),
        .count     (buf_count)
    );

    assign FIFO_READ_OUT  = read_out && !BUS_RST;
    assign FIFO_EMPTY_OUT = buf_empty;
    assign FRAME_CNT      = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_packer.sv
module tb_fifo_frame_packer;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST = 1'b1;
    logic        ENABLE = 1'b0;
    logic        FRAME_RST = 1'b0;
    logic        FIFO_EMPTY_IN = 1'b1;
    logic [31:0] FIFO_DATA_IN = 32'h0;
    logic        FIFO_READ_OUT;
    logic        FIFO_READ_IN = 1'b0;
    logic        FIFO_EMPTY_OUT;
    logic [31:0] FIFO_DATA_OUT;
    logic [23:0] FRAME_CNT;

    int          total = 0;
    int          bad = 0;

    logic [31:0] src_q[$];     // written by main only
    int          src_rd = 0;   // written by driver only
    logic [31:0] out_q[$];     // written by monitor only
    int          out_base = 0;
    logic [31:0] exp_q[$];
    logic        up_took = 1'b0;
    int          up_cnt = 0;
    int          stalls = 0;
    int          snap_up;
    int          snap_stall;

    fifo_frame_packer #(
        .WORDS_PER_FRAME (4),
        .HEADER_MARK     (8'hF5)
    ) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .ENABLE         (ENABLE),
        .FRAME_RST      (FRAME_RST),
        .FIFO_EMPTY_IN  (FIFO_EMPTY_IN),
        .FIFO_DATA_IN   (FIFO_DATA_IN),
        .FIFO_READ_OUT  (FIFO_READ_OUT),
        .FIFO_READ_IN   (FIFO_READ_IN),
        .FIFO_EMPTY_OUT (FIFO_EMPTY_OUT),
        .FIFO_DATA_OUT  (FIFO_DATA_OUT),
        .FRAME_CNT      (FRAME_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Inputs are stable from posedge+1 to the next posedge, so the negedge sees what the
    // coming edge will act on.
    always @(negedge BUS_CLK) begin
        up_took = !BUS_RST && FIFO_READ_OUT && !FIFO_EMPTY_IN;
        if (up_took) up_cnt++;
        if (!BUS_RST && !FIFO_EMPTY_IN && !FIFO_READ_OUT) stalls++;
        if (!BUS_RST && FIFO_READ_IN && !FIFO_EMPTY_OUT) out_q.push_back(FIFO_DATA_OUT);
    end

    // Upstream source: present the next queued word, advance after each accepted transfer.
    always @(posedge BUS_CLK) begin
        #1;
        if (up_took) src_rd++;
        if (src_rd < src_q.size()) begin
            FIFO_EMPTY_IN = 1'b0;
            FIFO_DATA_IN  = src_q[src_rd];
        end else begin
            FIFO_EMPTY_IN = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget);
        int c = 0;
        while ((out_q.size() - out_base) < n && c < budget) begin
            tick(1);
            c++;
        end
        if ((out_q.size() - out_base) < n) check_eq("timeout", out_q.size() - out_base, n);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_len"}, out_q.size() - out_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (out_base + i < out_q.size())
                check_eq($sformatf("%s[%0d]", tag, i), out_q[out_base + i], exp_q[i]);
        end
        out_base = out_q.size();
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(first + 32'(i));
    endtask

    initial begin
        tick(3);
        check_eq("rst_read_out", FIFO_READ_OUT, 0);
        check_eq("rst_empty_out", FIFO_EMPTY_OUT, 1);
        check_eq("rst_data_out", FIFO_DATA_OUT, 0);
        check_eq("rst_frame_cnt", FRAME_CNT, 0);
        BUS_RST = 1'b0;
        tick(2);

        // Pass-through, no framing.
        FIFO_READ_IN = 1'b1;
        snap_stall = stalls;
        push_words(32'h1, 5);
        wait_out(5, 100);
        tick(2);
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        check_stream("pass");
        check_eq("pass_frame_cnt", FRAME_CNT, 0);
        check_eq("pass_stalls", stalls - snap_stall, 0);

        // Framing with 4-word frames.
        ENABLE = 1'b1;
        tick(2);
        snap_stall = stalls;
        push_words(32'h10, 8);
        wait_out(10, 100);
        tick(2);
        exp_q = '{32'hF5000000, 32'h10, 32'h11, 32'h12, 32'h13,
                  32'hF5000001, 32'h14, 32'h15, 32'h16, 32'h17};
        check_stream("frame");
        check_eq("frame_cnt2", FRAME_CNT, 2);
        check_eq("frame_stalls", stalls - snap_stall, 2);

        // Backpressure: header plus one word fill the buffer, then upstream stalls.
        FIFO_READ_IN = 1'b0;
        snap_up = up_cnt;
        push_words(32'h20, 4);
        tick(8);
        check_eq("bp_empty_out", FIFO_EMPTY_OUT, 0);
        check_eq("bp_read_out", FIFO_READ_OUT, 0);
        check_eq("bp_accepted", up_cnt - snap_up, 1);
        check_eq("bp_no_pop", out_q.size() - out_base, 0);
        FIFO_READ_IN = 1'b1;
        wait_out(5, 100);
        tick(2);
        exp_q = '{32'hF5000002, 32'h20, 32'h21, 32'h22, 32'h23};
        check_stream("bp");
        check_eq("bp_frame_cnt", FRAME_CNT, 3);

        // ENABLE dropped mid-frame: the frame completes, then pass-through.
        push_words(32'h30, 2);
        wait_out(3, 100);
        tick(2);
        ENABLE = 1'b0;
        push_words(32'h32, 4);
        wait_out(7, 100);
        tick(2);
        exp_q = '{32'hF5000003, 32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35};
        check_stream("endrop");
        check_eq("endrop_frame_cnt", FRAME_CNT, 4);

        // Counter wrap: preload FFFFFF while idle in HDR.
        ENABLE = 1'b1;
        tick(2);
        force dut.frame_cnt_d = 24'hFFFFFF;
        tick(1);
        release dut.frame_cnt_d;
        tick(1);
        check_eq("wrap_preload", FRAME_CNT, 24'hFFFFFF);
        push_words(32'h40, 8);
        wait_out(10, 100);
        tick(2);
        exp_q = '{32'hF5FFFFFF, 32'h40, 32'h41, 32'h42, 32'h43,
                  32'hF5000000, 32'h44, 32'h45, 32'h46, 32'h47};
        check_stream("wrap");
        check_eq("wrap_frame_cnt", FRAME_CNT, 1);

        // FRAME_RST mid-frame.
        push_words(32'h50, 2);
        wait_out(3, 100);
        tick(2);
        FRAME_RST = 1'b1;
        tick(1);
        FRAME_RST = 1'b0;
        check_eq("frst_cnt", FRAME_CNT, 0);
        push_words(32'h52, 3);
        wait_out(7, 100);
        tick(2);
        exp_q = '{32'hF5000001, 32'h50, 32'h51, 32'h52, 32'h53, 32'hF5000000, 32'h54};
        check_stream("frst");
        check_eq("frst_frame_cnt", FRAME_CNT, 1);

        // BUS_RST with two words buffered mid-frame.
        FIFO_READ_IN = 1'b0;
        push_words(32'h60, 3);
        tick(6);
        check_eq("brst_pre_empty", FIFO_EMPTY_OUT, 0);
        check_eq("brst_pre_stall", FIFO_READ_OUT, 0);
        ENABLE = 1'b0;
        BUS_RST = 1'b1;
        #1;
        check_eq("brst_empty", FIFO_EMPTY_OUT, 1);
        check_eq("brst_cnt", FRAME_CNT, 0);
        check_eq("brst_read_out", FIFO_READ_OUT, 0);
        tick(2);
        BUS_RST = 1'b0;
        FIFO_READ_IN = 1'b1;
        push_words(32'h63, 1);
        wait_out(2, 100);
        tick(2);
        exp_q = '{32'h62, 32'h63};
        check_stream("brst");
        check_eq("brst_frame_cnt", FRAME_CNT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
